// File: rtl/sram_bridge.sv
// sram_bridge: multi-cycle LSU-word to async SRAM bridge with per-beat wait states.
// Define SRAM_BRIDGE_BEAT_SKIP_EN to skip write beats whose byte mask is all zero.
module sram_bridge #(
    parameter int ADDR_W   = 18,
    parameter int SRAM_DW  = 16,
    parameter int BUS_DW   = 32,
    parameter int WAIT_CYC = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_req,
    input  logic                 i_we,
    input  logic [31:0]          i_addr,
    input  logic [BUS_DW-1:0]    i_wdata,
    input  logic [BUS_DW/8-1:0]  i_bmask,
    output logic [BUS_DW-1:0]    o_rdata,
    output logic                 o_ack,
    output logic                 o_busy,
    output logic [ADDR_W-1:0]    SRAM_ADDR,
    inout  wire  [SRAM_DW-1:0]   SRAM_DQ,
    output logic                 SRAM_CE_N,
    output logic                 SRAM_WE_N,
    output logic                 SRAM_OE_N,
    output logic                 SRAM_LB_N,
    output logic                 SRAM_UB_N
);
    localparam int BEATS = BUS_DW / SRAM_DW;
    localparam int BPB   = SRAM_DW / 8;
    localparam int NB    = BUS_DW / 8;
    localparam int BW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int OFS   = $clog2(NB);
    localparam int BB    = $clog2(BEATS);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

    state_t              state;
    logic                we_r;
    logic [31:0]         addr_r;
    logic [BUS_DW-1:0]   wdata_r;
    logic [NB-1:0]       mask_r;
    logic [BW-1:0]       beat;
    logic [3:0]          cnt;
    logic                dq_oe;
    logic [SRAM_DW-1:0]  dq_out;

    logic                src_we;
    logic [31:0]         src_addr;
    logic [BUS_DW-1:0]   src_wdata;
    logic [NB-1:0]       src_mask;
    logic [BW:0]         first_b;
    logic                nxt_ok;
    logic [BW-1:0]       nxt;
    logic [BPB-1:0]      ms;
    logic [ADDR_W-1:0]   s_addr;
    logic [SRAM_DW-1:0]  s_dq;
    logic                s_lb;
    logic                s_ub;

    assign o_busy  = state != IDLE;
    assign SRAM_DQ = dq_oe ? dq_out : 'z;

    // Next beat setup values, from the live request in IDLE or the latched one in HOLD.
    always_comb begin
        src_we    = state == IDLE ? i_we : we_r;
        src_addr  = state == IDLE ? i_addr : addr_r;
        src_wdata = state == IDLE ? i_wdata : wdata_r;
        src_mask  = state == IDLE ? i_bmask : mask_r;
        first_b   = state == IDLE ? '0 : {1'b0, beat} + 1'b1;
        nxt_ok    = 1'b0;
        nxt       = '0;
        for (int i = BEATS - 1; i >= 0; i--)
`ifdef SRAM_BRIDGE_BEAT_SKIP_EN
            if (i >= int'(first_b) && (!src_we || |src_mask[i*BPB +: BPB])) begin
`else
            if (i >= int'(first_b)) begin
`endif
                nxt_ok = 1'b1;
                nxt    = BW'(i);
            end
        ms     = src_mask[nxt*BPB +: BPB];
        s_addr = ADDR_W'(((src_addr >> OFS) << BB) | 32'(nxt));
        s_dq   = src_wdata[nxt*SRAM_DW +: SRAM_DW];
        s_lb   = SRAM_DW == 8 || (src_we && !ms[0]);
        s_ub   = SRAM_DW == 8 || (src_we && !ms[BPB-1]);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            o_ack     <= 1'b0;
            o_rdata   <= '0;
            SRAM_ADDR <= '0;
            SRAM_CE_N <= 1'b1;
            SRAM_WE_N <= 1'b1;
            SRAM_OE_N <= 1'b1;
            SRAM_LB_N <= 1'b1;
            SRAM_UB_N <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
            we_r      <= 1'b0;
            addr_r    <= '0;
            wdata_r   <= '0;
            mask_r    <= '0;
            beat      <= '0;
            cnt       <= '0;
        end else begin
            o_ack <= 1'b0;
            case (state)
                IDLE: if (i_req) begin
                    we_r    <= i_we;
                    addr_r  <= i_addr;
                    wdata_r <= i_wdata;
                    mask_r  <= i_bmask;
                    if (nxt_ok) begin
                        state     <= SETUP;
                        beat      <= nxt;
                        SRAM_ADDR <= s_addr;
                        SRAM_CE_N <= 1'b0;
                        SRAM_OE_N <= i_we;
                        SRAM_LB_N <= s_lb;
                        SRAM_UB_N <= s_ub;
                        dq_out    <= s_dq;
                        dq_oe     <= i_we;
                    end else begin
                        state <= DONE;
                        o_ack <= 1'b1;
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    cnt       <= 4'(WAIT_CYC);
                    SRAM_WE_N <= !we_r;
                end
                ACCESS: if (cnt == 0) begin
                    state     <= HOLD;
                    SRAM_WE_N <= 1'b1;
                    SRAM_OE_N <= 1'b1;
                    if (!we_r)
                        o_rdata[beat*SRAM_DW +: SRAM_DW] <= SRAM_DQ;
                end else begin
                    cnt <= cnt - 1'b1;
                end
                HOLD: if (nxt_ok) begin
                    state     <= SETUP;
                    beat      <= nxt;
                    SRAM_ADDR <= s_addr;
                    SRAM_OE_N <= we_r;
                    SRAM_LB_N <= s_lb;
                    SRAM_UB_N <= s_ub;
                    dq_out    <= s_dq;
                    dq_oe     <= we_r;
                end else begin
                    state     <= DONE;
                    o_ack     <= 1'b1;
                    SRAM_CE_N <= 1'b1;
                    SRAM_LB_N <= 1'b1;
                    SRAM_UB_N <= 1'b1;
                    dq_oe     <= 1'b0;
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
